ram_port_arbiter: RTL and testbench
===================================

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 Parameter DW, 8, data width in bits.
REQ-002 Parameter AW, 6, address width; RAM depth = 2**AW words.
REQ-003 Port clk  input  1  single clock; all state updates on posedge clk.
REQ-004 Port rst_n  input  1  asynchronous active-low reset.
REQ-005 Ports req0/req1  input  1  requester i access request, held until granted.
REQ-006 Ports we0/we1  input  1  requester i write enable (1 = write, 0 = read), qualified by req.
REQ-007 Ports add0/add1  input  AW  requester i word address.
REQ-008 Ports d0/d1  input  DW  requester i write data.
REQ-009 Ports gnt0/gnt1  output  1  combinational grant; access accepted in the cycle where req and gnt are both high.
REQ-010 Ports qv0/qv1  output  1  registered; pulses one cycle after requester i's granted access.
REQ-011 Ports q0/q1  output  DW  registered return data, valid when qv is high.
REQ-012 Port busy  output  1  high while the post-reset clear sequence runs.

Function
REQ-013 The block SHALL own one single-port DW x 2**AW RAM and perform at most one access per cycle.
REQ-014 The FSM SHALL have two states, INIT and RUN; reset enters INIT.
REQ-015 In INIT the block SHALL write zero to address clr_ptr each cycle, clr_ptr incrementing from 0.
REQ-016 INIT SHALL go to RUN on the cycle after address 2**AW-1 is written, so INIT lasts exactly 2**AW cycles.
REQ-017 busy SHALL equal (state == INIT); gnt0 and gnt1 SHALL be 0 throughout INIT.
REQ-018 In RUN, gnt0 and gnt1 SHALL be one-hot or zero; gnt is never asserted without the matching req.
REQ-019 Only one requester active: that requester SHALL be granted in the same cycle.
REQ-020 Both requesters active: the winner SHALL follow the arbitration rule in REQ-028/029.
REQ-021 A granted write SHALL update the RAM at the clock edge and SHALL return q = written data with qv the next cycle (write-first).
REQ-022 A granted read SHALL return the RAM contents with qv exactly one cycle after the grant; read latency is 1.
REQ-023 A read granted in the cycle after a write to the same address SHALL return the new data.
REQ-024 qv of the non-granted requester SHALL be 0; q holds its last value when qv is 0.
REQ-025 Back-to-back grants to the same requester SHALL give qv high on consecutive cycles.

Reset
REQ-026 While rst_n = 0: state = INIT, clr_ptr = 0, priority pointer = requester 0, qv0 = qv1 = 0, q0 = q1 = 0, busy = 1.
REQ-027 Reset asserted mid-INIT or mid-RUN SHALL abort at once and restart INIT from address 0; in-flight qv pulses are dropped.

Configuration
REQ-028 With RAM_ARB_RR_EN defined, contention SHALL use round-robin:
- winner = requester named by the priority pointer
- after any grant, the pointer moves to the other requester
REQ-029 Without RAM_ARB_RR_EN, contention SHALL use fixed priority: requester 0 always wins, and the pointer register is not built.

Structure
REQ-030 A shared package SHALL hold:
- DW/AW default constants
- the INIT/RUN state enum
- the requester-index type
REQ-031 The RAM storage SHALL be one sub-module, ram_sp_wf:
- single port, write-first, 1-cycle registered read
- the arbiter drives its address/data/we mux

Verification
REQ-032 Scenario: reset release. busy = 1 for exactly 64 cycles, then 0; a read of any address after busy falls returns 0.
REQ-033 Scenario: single write/read. req0 writes 0xA5 to 0x10, then reads 0x10. gnt0 is high both cycles; q0 = 0xA5 with qv0 one cycle after each grant.
REQ-034 Scenario: round-robin contention (RAM_ARB_RR_EN). req0 and req1 held high for 4 cycles. Grants are 0,1,0,1; each qv follows its grant by one cycle.
REQ-035 Scenario: fixed-priority contention (macro undefined). req0 and req1 held high for 3 cycles. gnt0 = 1 every cycle and gnt1 = 0 until req0 drops.
REQ-036 Scenario: cross-requester forwarding. req1 writes 0x3C to 0x3F; in the next cycle req0 reads 0x3F. q0 = 0x3C.
REQ-037 Scenario: reset mid-RUN. Assert rst_n = 0 during a granted read. No qv pulse appears, busy returns to 1, and all addresses read 0 after the new INIT completes.

Source files
------------

// File: rtl/ram_port_arbiter_pkg.sv
// Shared types and defaults for the two-port RAM arbiter.
// Round-robin contention is enabled by defining RAM_ARB_RR_EN.
package ram_port_arbiter_pkg;

  localparam int DW_DEF = 8;
  localparam int AW_DEF = 6;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef logic req_idx_t;

  localparam req_idx_t REQ0 = 1'b0;
  localparam req_idx_t REQ1 = 1'b1;

endpackage

// File: rtl/ram_port_arbiter_sp_wf.sv
// Single-port write-first RAM with a one-cycle registered read.
// Contents are deliberately not reset; the arbiter clears them after reset.
module ram_sp_wf
  import ram_port_arbiter_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          en_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) begin
        mem_q[addr_i] <= wdata_i;
        rdata_q       <= wdata_i;
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter in front of one single-port RAM, cleared after reset.
// Define RAM_ARB_RR_EN for round-robin contention; default is fixed priority.
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] add0,
  input  logic [AW-1:0] add1,
  input  logic [DW-1:0] d0,
  input  logic [DW-1:0] d1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          qv0,
  output logic          qv1,
  output logic [DW-1:0] q0,
  output logic [DW-1:0] q1,
  output logic          busy
);

  state_e        state_q, state_d;
  logic [AW-1:0] clr_ptr_q, clr_ptr_d;
  logic          qv0_q, qv1_q;
  logic [DW-1:0] q0_hold_q, q1_hold_q;

  logic          g0, g1;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wd, ram_rd;

`ifdef RAM_ARB_RR_EN
  req_idx_t ptr_q, ptr_d;
`endif

  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
    if (state_q == RUN) begin
`ifdef RAM_ARB_RR_EN
      if (req0 && req1) begin
        g0 = (ptr_q == REQ0);
        g1 = (ptr_q == REQ1);
      end else begin
        g0 = req0;
        g1 = req1;
      end
`else
      g0 = req0;
      g1 = req1 & ~req0;
`endif
    end
  end

`ifdef RAM_ARB_RR_EN
  always_comb begin
    ptr_d = ptr_q;
    unique case (1'b1)
      g0:      ptr_d = REQ1;
      g1:      ptr_d = REQ0;
      default: ptr_d = ptr_q;
    endcase
  end
`endif

  // INIT owns the RAM port to write zeros; RUN hands it to the winner
  always_comb begin
    ram_en   = 1'b1;
    ram_we   = 1'b1;
    ram_addr = clr_ptr_q;
    ram_wd   = '0;
    if (state_q == RUN) begin
      ram_en   = g0 | g1;
      ram_we   = g1 ? we1 : we0;
      ram_addr = g1 ? add1 : add0;
      ram_wd   = g1 ? d1 : d0;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    if (state_q == INIT) begin
      clr_ptr_d = clr_ptr_q + AW'(1);
      if (&clr_ptr_q) state_d = RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= INIT;
      clr_ptr_q <= '0;
      qv0_q     <= 1'b0;
      qv1_q     <= 1'b0;
      q0_hold_q <= '0;
      q1_hold_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      qv0_q     <= g0;
      qv1_q     <= g1;
      if (qv0_q) q0_hold_q <= ram_rd;
      if (qv1_q) q1_hold_q <= ram_rd;
    end
  end

`ifdef RAM_ARB_RR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= REQ0;
    else        ptr_q <= ptr_d;
  end
`endif

  ram_sp_wf #(
    .DW(DW),
    .AW(AW)
  ) u_ram (
    .clk    (clk),
    .en_i   (ram_en),
    .we_i   (ram_we),
    .addr_i (ram_addr),
    .wdata_i(ram_wd),
    .rdata_o(ram_rd)
  );

  // The shared read register feeds whichever requester owns this cycle's pulse
  assign q0   = qv0_q ? ram_rd : q0_hold_q;
  assign q1   = qv1_q ? ram_rd : q1_hold_q;
  assign qv0  = qv0_q;
  assign qv1  = qv1_q;
  assign gnt0 = g0;
  assign gnt1 = g1;
  assign busy = (state_q == INIT);

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a per-cycle expectation queue.
// Contention expectations follow RAM_ARB_RR_EN when it is defined.
module tb_ram_port_arbiter;

  localparam int DW = 8;
  localparam int AW = 6;

  typedef struct {
    logic          v0;
    logic          v1;
    logic [DW-1:0] q0;
    logic [DW-1:0] q1;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0, req1, we0, we1;
  logic [AW-1:0] add0, add1;
  logic [DW-1:0] d0, d1;
  logic          gnt0, gnt1, qv0, qv1, busy;
  logic [DW-1:0] q0, q1;

  int            n_cmp = 0;
  int            n_err = 0;
  logic [DW-1:0] model [2**AW];
  logic [DW-1:0] lq0, lq1;
  exp_t          sb [$];

  always #5 clk = ~clk;

  ram_port_arbiter #(
    .DW(DW),
    .AW(AW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .req0 (req0),
    .req1 (req1),
    .we0  (we0),
    .we1  (we1),
    .add0 (add0),
    .add1 (add1),
    .d0   (d0),
    .d1   (d1),
    .gnt0 (gnt0),
    .gnt1 (gnt1),
    .qv0  (qv0),
    .qv1  (qv1),
    .q0   (q0),
    .q1   (q1),
    .busy (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 2**AW; i++) model[i] = '0;
    lq0 = '0;
    lq1 = '0;
    sb.delete();
  endtask

  // Starts just after a posedge; ends 1 time unit after the next posedge.
  task automatic step(input logic r0, input logic w0,
                      input logic [AW-1:0] a0, input logic [DW-1:0] x0,
                      input logic r1, input logic w1,
                      input logic [AW-1:0] a1, input logic [DW-1:0] x1,
                      input logic eg0, input logic eg1, input string tag);
    exp_t e;
    req0 = r0; we0 = w0; add0 = a0; d0 = x0;
    req1 = r1; we1 = w1; add1 = a1; d1 = x1;
    @(negedge clk);
    chk({tag, "/gnt0"}, 32'(gnt0), 32'(eg0));
    chk({tag, "/gnt1"}, 32'(gnt1), 32'(eg1));
    chk({tag, "/busy"}, 32'(busy), 32'(1'b0));
    if (eg0) begin
      if (w0) model[a0] = x0;
      lq0 = model[a0];
    end
    if (eg1) begin
      if (w1) model[a1] = x1;
      lq1 = model[a1];
    end
    e.v0 = eg0; e.v1 = eg1; e.q0 = lq0; e.q1 = lq1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({tag, "/qv0"}, 32'(qv0), 32'(e.v0));
    chk({tag, "/qv1"}, 32'(qv1), 32'(e.v1));
    chk({tag, "/q0"}, 32'(q0), 32'(e.q0));
    chk({tag, "/q1"}, 32'(q1), 32'(e.q1));
  endtask

  // Called at the negedge where rst_n is released.
  task automatic wait_init(input string tag);
    int   n = 0;
    logic g = 1'b0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      g = g | gnt0 | gnt1;
      @(negedge clk);
    end
    chk({tag, "/busy_cycles"}, 32'(n), 32'd64);
    chk({tag, "/init_gnt"}, 32'(g), 32'(1'b0));
    req0 = 1'b0;
    req1 = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    req0 = 1'b1; we0 = 1'b0; add0 = '0; d0 = '0;
    req1 = 1'b1; we1 = 1'b0; add1 = '0; d1 = '0;
    model_clear();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst/busy", 32'(busy), 32'(1'b1));
    chk("rst/gnt0", 32'(gnt0), 32'(1'b0));
    chk("rst/gnt1", 32'(gnt1), 32'(1'b0));
    chk("rst/qv0", 32'(qv0), 32'(1'b0));
    chk("rst/qv1", 32'(qv1), 32'(1'b0));
    chk("rst/q0", 32'(q0), 32'h0);
    chk("rst/q1", 32'(q1), 32'h0);
    rst_n = 1'b1;
    wait_init("init1");

    step(1, 0, 6'h00, 8'h00, 0, 0, 6'h00, 8'h00, 1, 0, "rd_00");
    step(1, 0, 6'h3F, 8'h00, 0, 0, 6'h00, 8'h00, 1, 0, "rd_3f");
    step(0, 0, 6'h00, 8'h00, 1, 0, 6'h25, 8'h00, 0, 1, "rd1_25");

    step(1, 1, 6'h10, 8'hA5, 0, 0, 6'h00, 8'h00, 1, 0, "wr_10");
    step(1, 0, 6'h10, 8'h00, 0, 0, 6'h00, 8'h00, 1, 0, "rd_10");
    step(0, 0, 6'h00, 8'h00, 0, 0, 6'h00, 8'h00, 0, 0, "idle");
    step(0, 0, 6'h00, 8'h00, 1, 0, 6'h10, 8'h00, 0, 1, "rd1_10");

`ifdef RAM_ARB_RR_EN
    step(1, 0, 6'h10, 8'h00, 1, 1, 6'h20, 8'h77, 1, 0, "rr_c0");
    step(1, 0, 6'h10, 8'h00, 1, 1, 6'h20, 8'h77, 0, 1, "rr_c1");
    step(1, 1, 6'h11, 8'h5A, 1, 0, 6'h20, 8'h00, 1, 0, "rr_c2");
    step(1, 0, 6'h11, 8'h00, 1, 0, 6'h20, 8'h00, 0, 1, "rr_c3");
`else
    step(1, 0, 6'h10, 8'h00, 1, 1, 6'h20, 8'h77, 1, 0, "fp_c0");
    step(1, 1, 6'h11, 8'h5A, 1, 1, 6'h20, 8'h77, 1, 0, "fp_c1");
    step(1, 0, 6'h11, 8'h00, 1, 1, 6'h20, 8'h77, 1, 0, "fp_c2");
    step(0, 0, 6'h00, 8'h00, 1, 1, 6'h20, 8'h77, 0, 1, "fp_c3");
`endif

    step(0, 0, 6'h00, 8'h00, 1, 1, 6'h3F, 8'h3C, 0, 1, "fw_wr1");
    step(1, 0, 6'h3F, 8'h00, 0, 0, 6'h00, 8'h00, 1, 0, "fw_rd0");

    req0 = 1'b1; we0 = 1'b0; add0 = 6'h3F;
    req1 = 1'b0;
    @(negedge clk);
    chk("mid/gnt0", 32'(gnt0), 32'(1'b1));
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("mid/qv0", 32'(qv0), 32'(1'b0));
    chk("mid/q0", 32'(q0), 32'h0);
    chk("mid/busy", 32'(busy), 32'(1'b1));
    req0 = 1'b0;
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    wait_init("init2");

    step(1, 0, 6'h3F, 8'h00, 0, 0, 6'h00, 8'h00, 1, 0, "post_3f");
    step(1, 0, 6'h10, 8'h00, 0, 0, 6'h00, 8'h00, 1, 0, "post_10");
    step(0, 0, 6'h00, 8'h00, 1, 0, 6'h20, 8'h00, 0, 1, "post_20");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
